// File: rtl/coder_pkg.sv
// Shared constants, FSM state type and modular-add helper for the QPP
// interleave/deinterleave datapath.
package coder_pkg;

  localparam int unsigned AW = 13;

  localparam int unsigned K_6144  = 6144;
  localparam int unsigned K_1056  = 1056;
  localparam int unsigned F1_6144 = 263;
  localparam int unsigned F2_6144 = 480;
  localparam int unsigned F1_1056 = 17;
  localparam int unsigned F2_1056 = 66;

  // Seeds for the second-order recursion: pi(j+1)-pi(j) starts at f1+f2 and grows by 2*f2.
  localparam int unsigned DELTA0_6144 = (F1_6144 + F2_6144) % K_6144;
  localparam int unsigned STEP_6144   = (2 * F2_6144) % K_6144;
  localparam int unsigned DELTA0_1056 = (F1_1056 + F2_1056) % K_1056;
  localparam int unsigned STEP_1056   = (2 * F2_1056) % K_1056;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // (a + b) mod k for a, b < k: one conditional subtract.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] k);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] k_of(input logic ksel);
    return ksel ? AW'(K_6144) : AW'(K_1056);
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Recursive QPP index generator: pi(j) = (f1*j + f2*j*j) mod K using two
// modular adders; shared with the decoder-side deinterleaver.
module qpp_addr_gen
  import coder_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          init,
  input  logic          ksel,
  input  logic          advance,
  input  logic [AW-1:0] k,
  output logic [AW-1:0] pi
);

  logic [AW-1:0] pi_q, pi_d;
  logic [AW-1:0] delta_q, delta_d;
  logic [AW-1:0] step_q, step_d;

  always_comb begin
    pi_d    = pi_q;
    delta_d = delta_q;
    step_d  = step_q;
    if (init) begin
      pi_d    = '0;
      delta_d = ksel ? AW'(DELTA0_6144) : AW'(DELTA0_1056);
      step_d  = ksel ? AW'(STEP_6144)   : AW'(STEP_1056);
    end else if (advance) begin
      pi_d    = mod_add(pi_q, delta_q, k);
      delta_d = mod_add(delta_q, step_q, k);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pi_q    <= '0;
      delta_q <= '0;
      step_q  <= '0;
    end else begin
      pi_q    <= pi_d;
      delta_q <= delta_d;
      step_q  <= step_d;
    end
  end

  assign pi = pi_q;

endmodule

// File: rtl/coder_interleaver_ctrl.sv
// Turbo-encoder QPP interleaver: loads K bits in natural order, then streams
// them out as out[j] = in[pi(j)] with valid/ready handshakes on both sides.
module coder_interleaver_ctrl
  import coder_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          K_eq_6144,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic [AW-1:0] out_index,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          ksel_q, ksel_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] j_q, j_d;
  logic          mem_q [0:K_6144-1];

  logic [AW-1:0] k_c;
  logic [AW-1:0] pi_c;
  logic          in_xfer_c, out_xfer_c, last_in_c, last_out_c;
  logic          qpp_init_c, qpp_adv_c;

  assign k_c        = k_of(ksel_q);
  assign in_xfer_c  = in_valid  && (state_q == ST_LOAD);
  assign out_xfer_c = out_ready && (state_q == ST_OUT);
  assign last_in_c  = (wr_cnt_q == k_c - AW'(1));
  assign last_out_c = (j_q == k_c - AW'(1));

  // Next-state and counter control.
  always_comb begin
    state_d    = state_q;
    ksel_d     = ksel_q;
    wr_cnt_d   = wr_cnt_q;
    j_d        = j_q;
    qpp_init_c = 1'b0;
    qpp_adv_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ksel_d   = K_eq_6144;
          wr_cnt_d = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_xfer_c) begin
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (last_in_c) begin
            state_d    = ST_OUT;
            j_d        = '0;
            qpp_init_c = 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (out_xfer_c) begin
          qpp_adv_c = 1'b1;
          if (last_out_c) begin
            state_d = ST_IDLE;
            j_d     = '0;
          end else begin
            j_d = j_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ksel_q   <= 1'b0;
      wr_cnt_q <= '0;
      j_q      <= '0;
    end else begin
      state_q  <= state_d;
      ksel_q   <= ksel_d;
      wr_cnt_q <= wr_cnt_d;
      j_q      <= j_d;
    end
  end

  // Single-port bit buffer; contents are meaningless outside a block.
  always_ff @(posedge clk) begin
    if (in_xfer_c) mem_q[wr_cnt_q] <= in_bit;
  end

  qpp_addr_gen u_qpp (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (qpp_init_c),
    .ksel    (ksel_q),
    .advance (qpp_adv_c),
    .k       (k_c),
    .pi      (pi_c)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_last  = out_valid && last_out_c;
  assign out_index = j_q;
  assign out_bit   = mem_q[pi_c];

endmodule

// File: tb/tb_coder_interleaver_ctrl.sv
// Self-checking bench: block table run through a scoreboard built from a
// direct (multiplying) QPP reference, plus reset, start-glitch and abort cases.
module tb_coder_interleaver_ctrl;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          reset_n, start, K_eq_6144, in_valid, in_bit, out_ready;
  logic          in_ready, out_valid, out_bit, out_last, busy;
  logic [AW-1:0] out_index;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          b;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic ksel;
    bit   bp;
    bit   glitch;
    int   abort_at;
  } blk_t;

  typedef struct {
    logic ksel;
    int   j;
    int   pi;
  } pi_vec_t;

  exp_t    sb [$];
  logic    inbits [0:6143];
  blk_t    blocks [7];
  pi_vec_t pi_tab [9];

  always #5 clk = ~clk;

  coder_interleaver_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .K_eq_6144 (K_eq_6144),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_index (out_index),
    .busy      (busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},      longint'(busy), 0);
    chk({tag, "_in_ready"},  longint'(in_ready), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_last"},  longint'(out_last), 0);
    chk({tag, "_out_index"}, longint'(out_index), 0);
  endtask

  function automatic int ref_pi(input logic ks, input int j);
    longint k, f1, f2;
    k  = ks ? 6144 : 1056;
    f1 = ks ? 263 : 17;
    f2 = ks ? 480 : 66;
    return int'((f1 * j + f2 * longint'(j) * j) % k);
  endfunction

  task automatic run_block(input blk_t b);
    int   k, loaded, n, cyc;
    logic rdy;
    exp_t e;
    k = b.ksel ? 6144 : 1056;
    @(posedge clk); #1;
    start = 1'b1; K_eq_6144 = b.ksel;
    @(posedge clk); #1;
    start = 1'b0; K_eq_6144 = ~b.ksel;
    chk("start_busy", longint'(busy), 1);
    chk("start_in_ready", longint'(in_ready), 1);

    loaded = 0; cyc = 0;
    while (loaded < k && cyc < 4 * k) begin
      in_valid = b.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      start    = b.glitch && (loaded == k / 2);
      rdy      = in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        inbits[loaded] = in_bit;
        loaded++;
      end
      cyc++;
      #1;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("load_count", loaded, k);
    chk("first_out_latency", longint'(out_valid), 1);
    chk("load_in_ready_low", longint'(in_ready), 0);

    for (int j = 0; j < k; j++) begin
      e.b    = inbits[ref_pi(b.ksel, j)];
      e.idx  = AW'(j);
      e.last = (j == k - 1);
      sb.push_back(e);
    end

    n = 0; cyc = 0;
    while (n < k && cyc < 4 * k) begin
      out_ready = b.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      start     = b.glitch && ((sb.size() == 1 && out_ready) || n == k / 2);
      e = sb[0];
      chk("out_valid", longint'(out_valid), 1);
      chk("out_bit", longint'(out_bit), longint'(e.b));
      chk("out_index", longint'(out_index), longint'(e.idx));
      chk("out_last", longint'(out_last), longint'(e.last));
      foreach (pi_tab[i])
        if (pi_tab[i].ksel == b.ksel && pi_tab[i].j == n && out_ready)
          chk("pi_seq", longint'(dut.u_qpp.pi_q), pi_tab[i].pi);
      if (b.abort_at >= 0 && n == b.abort_at) begin
        out_ready = 1'b0; start = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_idle_outputs("abort");
        sb.delete();
        @(posedge clk); #1;
        chk_idle_outputs("abort_hold");
        return;
      end
      @(posedge clk);
      if (out_ready) begin
        void'(sb.pop_front());
        n++;
      end
      cyc++;
      #1;
    end
    out_ready = 1'b0; start = 1'b0;
    chk("out_count", n, k);
    chk("end_out_valid", longint'(out_valid), 0);
    chk("end_busy", longint'(busy), 0);
    @(posedge clk); #1;
    chk("end_busy_hold", longint'(busy), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    blocks[0] = '{ksel: 1'b1, bp: 1'b0, glitch: 1'b0, abort_at: -1};
    blocks[1] = '{ksel: 1'b0, bp: 1'b0, glitch: 1'b0, abort_at: -1};
    blocks[2] = '{ksel: 1'b0, bp: 1'b1, glitch: 1'b1, abort_at: -1};
    blocks[3] = '{ksel: 1'b1, bp: 1'b1, glitch: 1'b1, abort_at: -1};
    blocks[4] = '{ksel: 1'b0, bp: 1'b0, glitch: 1'b1, abort_at: -1};
    blocks[5] = '{ksel: 1'b0, bp: 1'b1, glitch: 1'b0, abort_at: 300};
    blocks[6] = '{ksel: 1'b0, bp: 1'b0, glitch: 1'b0, abort_at: -1};

    pi_tab[0] = '{ksel: 1'b1, j: 0, pi: 0};
    pi_tab[1] = '{ksel: 1'b1, j: 1, pi: 743};
    pi_tab[2] = '{ksel: 1'b1, j: 2, pi: 2446};
    pi_tab[3] = '{ksel: 1'b1, j: 3, pi: 5109};
    pi_tab[4] = '{ksel: 1'b0, j: 0, pi: 0};
    pi_tab[5] = '{ksel: 1'b0, j: 1, pi: 83};
    pi_tab[6] = '{ksel: 1'b0, j: 2, pi: 298};
    pi_tab[7] = '{ksel: 1'b0, j: 3, pi: 645};
    pi_tab[8] = '{ksel: 1'b0, j: 4, pi: 68};

    reset_n = 1'b0; start = 1'b0; K_eq_6144 = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;

    // Reset held while start and in_valid toggle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = i[0]; in_valid = 1'b1; in_bit = i[1];
      @(posedge clk); #1;
      chk_idle_outputs("reset");
    end
    start = 1'b0; in_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      chk_idle_outputs("post_reset");
    end
    in_valid = 1'b0;

    foreach (blocks[i]) run_block(blocks[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
